risc_prog_loader: RTL and testbench
===================================

// Module: risc_prog_loader
// PURPOSE
//  Upstream program-load stage for the risc core. Receives a framed byte stream
//  from an external host over an asynchronous strobe handshake. Writes the payload
//  into core instruction memory through the inst_address/inst_data/inst_we write port,
//  verifies an 8-bit checksum, and releases the core from reset only after a good load.
// PARAMETERS
//  ADDR_W   7      instruction address width; memory DEPTH = 2**ADDR_W (128)
//  DATA_W   8      instruction/data byte width
//  TIMEOUT  50000  idle clk cycles allowed between bytes while loading; 0 = no timeout
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       synchronous active-low reset
//  host_data    in   DATA_W  host byte; must be stable from strobe rise until next strobe
//  host_strobe  in   1       async level; each rising edge = one byte presented
//  host_start   in   1       async level; a rising edge starts or restarts a load
//  inst_address out  ADDR_W  write address to instruction memory
//  inst_data    out  DATA_W  write data to instruction memory
//  inst_we      out  1       one-cycle write pulse
//  cpu_rst_n    out  1       active-low reset to the core; 1 only in state RUN
//  load_done    out  1       1 in RUN
//  load_err     out  1       1 in ERROR
//  state_o      out  2       00 IDLE, 01 LOAD, 10 RUN, 11 ERROR
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state IDLE, all outputs 0, counters and checksum
//    cleared, sync flops 0. Reset overrides everything, including mid-load.
//  - host_strobe and host_start each pass through a 2-flop synchronizer plus a
//    previous-value flop. An event is sync2 & ~prev.
//  - A strobe event captures host_data into a byte register on the same edge.
//  - Frame after a start event: LEN byte, then LEN payload bytes, then CSUM byte.
//    LEN must be 1..DEPTH. CSUM = (sum of payload bytes) mod 256.
//  - FSM:
//    - IDLE: start event -> LOAD. Clear addr, csum and count; expect LEN.
//    - LOAD, LEN phase:
//      - LEN==0 or LEN>DEPTH -> ERROR.
//      - Otherwise store LEN and expect payload.
//    - LOAD, payload phase:
//      - On each byte, inst_data<=byte and inst_address<=count.
//      - inst_we=1 for exactly one cycle, on the edge after the capture.
//      - csum+=byte (8-bit wrap) and count++.
//      - When count reaches LEN, expect CSUM.
//    - LOAD, CSUM phase: match -> RUN, mismatch -> ERROR.
//    - RUN and ERROR are sticky until a start event (-> LOAD) or reset.
//    - A start event in LOAD restarts the load: counters cleared, pending inst_we
//      still completes, memory is not erased.
//  - Latency: a host_strobe rise first sampled at edge k gives inst_we=1 during the
//    cycle after edge k+3.
//  - cpu_rst_n is asserted (0) in IDLE, LOAD and ERROR. It is deasserted on the same
//    edge that enters RUN.
//  - Timeout: in LOAD with TIMEOUT!=0, the idle counter resets on every strobe event.
//    Reaching TIMEOUT -> ERROR.
//  - Simultaneous start and strobe events: start wins and the strobe byte is dropped.
//  - Address wrap cannot occur: LEN<=DEPTH bounds count to DEPTH-1.
//  - Strobe events in IDLE, RUN or ERROR are ignored (no writes).
//  - inst_address and inst_data hold their last values when inst_we=0.
// TESTING
//  1 Start, LEN=3, bytes 11 22 33, CSUM=66 -> writes (0,11),(1,22),(2,33), one we pulse
//    each; state_o=10, cpu_rst_n=1, load_done=1.
//  2 Start, LEN=2, bytes 80 90, CSUM=00 -> two writes; 80+90 wraps to 10 so mismatch:
//    state_o=11, load_err=1, cpu_rst_n=0.
//  3 Start, LEN=00; then a separate start with LEN=81 -> ERROR on each LEN byte, zero
//    inst_we pulses. LEN=80 with a correct CSUM -> 128 writes, addr 0..7F, RUN.
//  4 TIMEOUT=20: start, LEN=4, 2 bytes, then silence -> ERROR exactly 20 cycles after
//    the last strobe event.
//  5 Start, LEN=4, 2 bytes; start again; LEN=1, byte 5A, CSUM 5A -> new writes begin at
//    addr 0, RUN.
//  6 rst_n=0 for 1 cycle mid-payload -> all outputs 0 and IDLE next cycle; later strobes
//    cause no writes.
//    Also check: strobe held high continuously gives one event; start together with a
//    strobe drops the byte.

Source files
------------

// File: rtl/risc_prog_loader.sv
// Program loader for the risc core: receives a framed, checksummed byte stream from an
// asynchronous host, writes the payload into instruction memory and then releases the core.
module risc_prog_loader #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_strobe,
  input  logic              host_start,
  output logic [ADDR_W-1:0] inst_address,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_we,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        state_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  // Count and length need one extra bit so that LEN == DEPTH is representable.
  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] IdleLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StRun   = 2'b10,
    StError = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PhLen,
    PhData,
    PhCsum
  } phase_e;

  logic r_stb_s1, r_stb_s2, r_stb_prev;
  logic r_sta_s1, r_sta_s2, r_sta_prev;
  logic w_stb_ev, w_sta_ev;

  logic [DATA_W-1:0] r_byte;
  logic              r_byte_vld;

  state_e            r_state, w_state_d;
  phase_e            r_phase, w_phase_d;
  logic [CW-1:0]     r_len, w_len_d;
  logic [CW-1:0]     r_count, w_count_d;
  logic [DATA_W-1:0] r_csum, w_csum_d;
  logic [TW-1:0]     r_idle, w_idle_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_data, w_data_d;
  logic              r_we, w_we_d;
  logic              w_len_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stb_s1   <= 1'b0;
      r_stb_s2   <= 1'b0;
      r_stb_prev <= 1'b0;
      r_sta_s1   <= 1'b0;
      r_sta_s2   <= 1'b0;
      r_sta_prev <= 1'b0;
    end else begin
      r_stb_s1   <= host_strobe;
      r_stb_s2   <= r_stb_s1;
      r_stb_prev <= r_stb_s2;
      r_sta_s1   <= host_start;
      r_sta_s2   <= r_sta_s1;
      r_sta_prev <= r_sta_s2;
    end
  end

  assign w_stb_ev = r_stb_s2 & ~r_stb_prev;
  assign w_sta_ev = r_sta_s2 & ~r_sta_prev;

  // A byte is only queued for processing while loading and when no start event wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      if (w_stb_ev) begin
        r_byte <= host_data;
      end
      r_byte_vld <= w_stb_ev & ~w_sta_ev & (r_state == StLoad);
    end
  end

  assign w_len_ok = (r_byte != '0) && (32'(r_byte) <= DEPTH);

  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_len_d   = r_len;
    w_count_d = r_count;
    w_csum_d  = r_csum;
    w_idle_d  = r_idle;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_we_d    = 1'b0;

    if (w_sta_ev) begin
      w_state_d = StLoad;
      w_phase_d = PhLen;
      w_len_d   = '0;
      w_count_d = '0;
      w_csum_d  = '0;
      w_idle_d  = '0;
    end else if (r_state == StLoad) begin
      if (w_stb_ev) begin
        w_idle_d = '0;
      end else if (TIMEOUT != 0) begin
        w_idle_d = r_idle + TW'(1);
      end

      if (r_byte_vld) begin
        unique case (r_phase)
          PhLen: begin
            if (w_len_ok) begin
              w_len_d   = CW'(r_byte);
              w_phase_d = PhData;
            end else begin
              w_state_d = StError;
            end
          end
          PhData: begin
            w_addr_d  = r_count[ADDR_W-1:0];
            w_data_d  = r_byte;
            w_we_d    = 1'b1;
            w_csum_d  = r_csum + r_byte;
            w_count_d = r_count + CW'(1);
            if (w_count_d == r_len) begin
              w_phase_d = PhCsum;
            end
          end
          PhCsum: begin
            w_state_d = (r_byte == r_csum) ? StRun : StError;
          end
          default: begin
            w_state_d = StError;
          end
        endcase
      end

      if ((TIMEOUT != 0) && !w_stb_ev && (r_idle == IdleLast)) begin
        w_state_d = StError;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_phase <= PhLen;
      r_len   <= '0;
      r_count <= '0;
      r_csum  <= '0;
      r_idle  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_len   <= w_len_d;
      r_count <= w_count_d;
      r_csum  <= w_csum_d;
      r_idle  <= w_idle_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_we    <= w_we_d;
    end
  end

  assign inst_address = r_addr;
  assign inst_data    = r_data;
  assign inst_we      = r_we;
  assign cpu_rst_n    = (r_state == StRun);
  assign load_done    = (r_state == StRun);
  assign load_err     = (r_state == StError);
  assign state_o      = r_state;

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader: frame vectors from a table plus hand-written
// sequences for latency, restart, timeout, held strobe and mid-load reset.
module tb_risc_prog_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] host_data;
  logic       host_strobe;
  logic       host_start;
  logic [6:0] inst_address;
  logic [7:0] inst_data;
  logic       inst_we;
  logic       cpu_rst_n;
  logic       load_done;
  logic       load_err;
  logic [1:0] state_o;

  risc_prog_loader #(
    .ADDR_W (7),
    .DATA_W (8),
    .TIMEOUT(20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_data   (host_data),
    .host_strobe (host_strobe),
    .host_start  (host_start),
    .inst_address(inst_address),
    .inst_data   (inst_data),
    .inst_we     (inst_we),
    .cpu_rst_n   (cpu_rst_n),
    .load_done   (load_done),
    .load_err    (load_err),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dbl    = 0;
  logic prev_we = 1'b0;
  logic [6:0] wa[$];
  logic [7:0] wd[$];

  // Write monitor: records every write and flags back-to-back we pulses.
  always @(negedge clk) begin
    if (inst_we && prev_we) n_dbl++;
    prev_we = inst_we;
    if (inst_we) begin
      wa.push_back(inst_address);
      wd.push_back(inst_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    host_data   = b;
    host_strobe = 1'b1;
    repeat (3) @(negedge clk);
    host_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    host_start = 1'b1;
    repeat (3) @(negedge clk);
    host_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [1:0] st);
    chk({nm, "_state"}, 32'(state_o), 32'(st));
    chk({nm, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(st == 2'b10));
    chk({nm, "_done"}, 32'(load_done), 32'(st == 2'b10));
    chk({nm, "_err"}, 32'(load_err), 32'(st == 2'b11));
  endtask

  task automatic chk_write(input string nm, input int idx, input logic [6:0] a,
                           input logic [7:0] d);
    if (idx < wa.size()) begin
      chk($sformatf("%s_addr%0d", nm, idx), 32'(wa[idx]), 32'(a));
      chk($sformatf("%s_data%0d", nm, idx), 32'(wd[idx]), 32'(d));
    end
  endtask

  typedef struct {
    logic [7:0]      len;
    int              n;
    logic [3:0][7:0] pl;
    logic [7:0]      cs;
    bit              send_cs;
    logic [1:0]      st;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 8'h03, n: 3, pl: {8'h00, 8'h33, 8'h22, 8'h11}, cs: 8'h66,
                send_cs: 1'b1, st: 2'b10};
    vecs[1] = '{len: 8'h02, n: 2, pl: {8'h00, 8'h00, 8'h90, 8'h80}, cs: 8'h00,
                send_cs: 1'b1, st: 2'b11};
    vecs[2] = '{len: 8'h00, n: 0, pl: '0, cs: 8'h00, send_cs: 1'b0, st: 2'b11};
    vecs[3] = '{len: 8'h81, n: 0, pl: '0, cs: 8'h00, send_cs: 1'b0, st: 2'b11};
    vecs[4] = '{len: 8'h01, n: 1, pl: {8'h00, 8'h00, 8'h00, 8'hFF}, cs: 8'hFF,
                send_cs: 1'b1, st: 2'b10};
    vecs[5] = '{len: 8'h04, n: 4, pl: {8'h04, 8'h03, 8'h02, 8'h01}, cs: 8'h0A,
                send_cs: 1'b1, st: 2'b10};
    vecs[6] = '{len: 8'h04, n: 4, pl: {8'h04, 8'h03, 8'h02, 8'h01}, cs: 8'h0B,
                send_cs: 1'b1, st: 2'b11};

    rst_n       = 1'b0;
    host_data   = 8'h00;
    host_strobe = 1'b0;
    host_start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 2'b00);
    chk("reset_we", 32'(inst_we), 32'd0);
    chk("reset_addr", 32'(inst_address), 32'd0);
    chk("reset_data", 32'(inst_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      wa.delete();
      wd.delete();
      pulse_start();
      send_byte(vecs[i].len);
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].pl[j]);
      if (vecs[i].send_cs) send_byte(vecs[i].cs);
      settle();
      chk_state($sformatf("v%0d", i), vecs[i].st);
      chk($sformatf("v%0d_nwrites", i), 32'(wa.size()), 32'(vecs[i].n));
      for (int j = 0; j < vecs[i].n; j++)
        chk_write($sformatf("v%0d", i), j, 7'(j), vecs[i].pl[j]);
    end

    // Strobe-to-write latency: rise first sampled at edge k gives we after edge k+3
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h01);
    @(negedge clk);
    host_data   = 8'h3C;
    host_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("lat_we_k2", 32'(inst_we), 32'd0);
    @(posedge clk);
    #1 chk("lat_we_k3", 32'(inst_we), 32'd1);
    chk("lat_addr", 32'(inst_address), 32'd0);
    chk("lat_data", 32'(inst_data), 32'h3C);
    @(posedge clk);
    #1 chk("lat_we_k4", 32'(inst_we), 32'd0);
    @(negedge clk);
    host_strobe = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h3C);
    settle();
    chk_state("lat", 2'b10);

    // Full-depth load: 128 bytes 0..127, checksum 8128 mod 256 = C0
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h80);
    for (int j = 0; j < 128; j++) send_byte(8'(j));
    send_byte(8'hC0);
    settle();
    chk_state("full", 2'b10);
    chk("full_nwrites", 32'(wa.size()), 32'd128);
    for (int j = 0; j < 128; j++) chk_write("full", j, 7'(j), 8'(j));

    // Restart mid-payload; strobes in RUN are ignored afterwards
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h5A);
    settle();
    chk_state("restart", 2'b10);
    send_byte(8'hEE);
    settle();
    chk("restart_nwrites", 32'(wa.size()), 32'd3);
    chk_write("restart", 0, 7'h00, 8'hAA);
    chk_write("restart", 1, 7'h01, 8'hBB);
    chk_write("restart", 2, 7'h00, 8'h5A);
    chk_state("restart_run_ign", 2'b10);

    // Strobe held high for many cycles counts as a single byte
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h02);
    @(negedge clk);
    host_data   = 8'h11;
    host_strobe = 1'b1;
    repeat (10) @(negedge clk);
    host_strobe = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h22);
    send_byte(8'h33);
    settle();
    chk_state("held", 2'b10);
    chk("held_nwrites", 32'(wa.size()), 32'd2);
    chk_write("held", 0, 7'h00, 8'h11);
    chk_write("held", 1, 7'h01, 8'h22);

    // Start and strobe together: start wins, byte dropped
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h10);
    @(negedge clk);
    host_data   = 8'h77;
    host_strobe = 1'b1;
    host_start  = 1'b1;
    repeat (3) @(negedge clk);
    host_strobe = 1'b0;
    host_start  = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h05);
    settle();
    chk_state("coinc", 2'b10);
    chk("coinc_nwrites", 32'(wa.size()), 32'd2);
    chk_write("coinc", 0, 7'h00, 8'h10);
    chk_write("coinc", 1, 7'h00, 8'h05);

    // Timeout: ERROR exactly 20 cycles after the edge that sees the last strobe event
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'hA1);
    @(negedge clk);
    host_data   = 8'hA2;
    host_strobe = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk);
      if (i == 4) #1 host_strobe = 1'b0;
    end
    #1 chk("tmo_state_e19", 32'(state_o), 32'd1);
    @(posedge clk);
    #1 chk_state("tmo", 2'b11);
    chk("tmo_nwrites", 32'(wa.size()), 32'd2);

    // Reset for one cycle mid-payload
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h44);
    send_byte(8'h55);
    chk("prerst_addr", 32'(inst_address), 32'd1);
    @(negedge clk);
    host_data   = 8'h66;
    host_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_state("midrst", 2'b00);
    chk("midrst_we", 32'(inst_we), 32'd0);
    chk("midrst_addr", 32'(inst_address), 32'd0);
    chk("midrst_data", 32'(inst_data), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    host_strobe = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    settle();
    chk_state("postrst", 2'b00);
    chk("postrst_nwrites", 32'(wa.size()), 32'd2);

    chk("we_single_cycle", 32'(n_dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
